// File: rtl/wm8960_pkg.sv
// Shared definitions for the WM8960 I2C write arbiter.
// Holds the arbiter state encoding, requester index constants, the
// codec's 8-bit write address and a few frequently used register numbers.
package wm8960_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } arb_state_t;

    localparam logic [1:0] REQ_INIT = 2'd0;
    localparam logic [1:0] REQ_UART = 2'd1;
    localparam logic [1:0] REQ_KEY  = 2'd2;

    localparam logic [7:0] WM8960_DEV_ADDR = 8'h34;

    localparam logic [6:0] WM8960_REG_LOUT1 = 7'h02;
    localparam logic [6:0] WM8960_REG_ROUT1 = 7'h03;
    localparam logic [6:0] WM8960_REG_RESET = 7'h0F;

endpackage

// File: rtl/wm8960_req_sel.sv
// Requester selector for the WM8960 I2C arbiter (purely combinational).
// Ports:
//   eligible    - requests that may be served this cycle (bit 0 = init)
//   rr_last     - index of the last successfully served requester among 1/2
//   grant_valid - at least one eligible request
//   grant_idx   - index of the winning requester
module wm8960_req_sel
    import wm8960_pkg::*;
(
    input  logic [2:0] eligible,
    input  logic [1:0] rr_last,
    output logic       grant_valid,
    output logic [1:0] grant_idx
);

    // The init sequencer always wins; UART and key control alternate
    // when both are waiting, favouring whichever was not served last.
    always_comb begin
        grant_valid = |eligible;
        grant_idx   = REQ_INIT;
        if (eligible[0]) begin
            grant_idx = REQ_INIT;
        end else if (eligible[1] && eligible[2]) begin
            grant_idx = (rr_last == REQ_UART) ? REQ_KEY : REQ_UART;
        end else if (eligible[1]) begin
            grant_idx = REQ_UART;
        end else if (eligible[2]) begin
            grant_idx = REQ_KEY;
        end
    end

endmodule

// File: rtl/wm8960_i2c_arbiter.sv
// Shares the WM8960 I2C register-write master between the init sequencer,
// the UART command decoder and the key volume/mute control.
// Ports:
//   Clk, Rst_n              - clock, asynchronous active-low reset
//   init_done               - until high only requester 0 is eligible
//   req[2:0]                - level requests, held until done/err pulse
//   req_addr0..2, req_data0..2 - 7-bit register / 9-bit data per requester
//   grant_done, grant_err   - one-cycle completion pulses per requester
//   busy                    - arbiter not idle
//   m_go, m_dev_addr, m_byte_hi, m_byte_lo - command to the I2C byte engine
//   m_done, m_ack_err       - transaction end strobe and NACK flag
module wm8960_i2c_arbiter
    import wm8960_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR    = WM8960_DEV_ADDR,
    parameter int          TIMEOUT_CYC = 50000,
    parameter int          RETRY_MAX   = 2,
    parameter int          GAP_CYC     = 100
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       init_done,
    input  logic [2:0] req,
    input  logic [6:0] req_addr0,
    input  logic [6:0] req_addr1,
    input  logic [6:0] req_addr2,
    input  logic [8:0] req_data0,
    input  logic [8:0] req_data1,
    input  logic [8:0] req_data2,
    output logic [2:0] grant_done,
    output logic [2:0] grant_err,
    output logic       busy,
    output logic       m_go,
    output logic [7:0] m_dev_addr,
    output logic [7:0] m_byte_hi,
    output logic [7:0] m_byte_lo,
    input  logic       m_done,
    input  logic       m_ack_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam int RW = $clog2(RETRY_MAX + 2);

    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYC - 1);
    localparam logic [RW-1:0] RETRY_LIM  = RW'(RETRY_MAX);

    arb_state_t    state, state_n;
    logic [1:0]    idx, idx_n;
    logic [1:0]    rr_last, rr_last_n;
    logic [RW-1:0] retry_cnt, retry_cnt_n;
    logic          retry_flag, retry_flag_n;
    logic [TW-1:0] timer, timer_n;
    logic [GW-1:0] gap_cnt, gap_cnt_n;
    logic [7:0]    byte_hi_n, byte_lo_n;
    logic          go_n;
    logic [2:0]    done_n, err_n;

    logic [2:0]    eligible;
    logic          sel_valid;
    logic [1:0]    sel_idx;
    logic [6:0]    sel_addr;
    logic [8:0]    sel_data;

    assign eligible   = req & {init_done, init_done, 1'b1};
    assign busy       = (state != IDLE);
    assign m_dev_addr = DEV_ADDR;

    wm8960_req_sel u_req_sel (
        .eligible    (eligible),
        .rr_last     (rr_last),
        .grant_valid (sel_valid),
        .grant_idx   (sel_idx)
    );

    // Operands of the current winner, latched only in IDLE so later
    // changes on the request inputs cannot disturb a transaction.
    always_comb begin
        sel_addr = req_addr0;
        sel_data = req_data0;
        case (sel_idx)
            REQ_UART: begin
                sel_addr = req_addr1;
                sel_data = req_data1;
            end
            REQ_KEY: begin
                sel_addr = req_addr2;
                sel_data = req_data2;
            end
            default: begin
                sel_addr = req_addr0;
                sel_data = req_data0;
            end
        endcase
    end

    // Next-state and next-output logic. All outputs are registered, so
    // m_go rises two edges after a request appears in IDLE and the
    // grant pulses follow the edge that samples m_done.
    always_comb begin
        state_n      = state;
        idx_n        = idx;
        rr_last_n    = rr_last;
        retry_cnt_n  = retry_cnt;
        retry_flag_n = retry_flag;
        timer_n      = timer;
        gap_cnt_n    = gap_cnt;
        byte_hi_n    = m_byte_hi;
        byte_lo_n    = m_byte_lo;
        go_n         = 1'b0;
        done_n       = 3'b000;
        err_n        = 3'b000;

        case (state)
            IDLE: begin
                if (sel_valid) begin
                    idx_n       = sel_idx;
                    byte_hi_n   = {sel_addr, sel_data[8]};
                    byte_lo_n   = sel_data[7:0];
                    retry_cnt_n = '0;
                    state_n     = ISSUE;
                end
            end
            ISSUE: begin
                go_n    = 1'b1;
                timer_n = '0;
                state_n = WAIT;
            end
            WAIT: begin
                timer_n = timer + 1'b1;
                // m_done takes precedence over a coincident timeout
                if (m_done) begin
                    gap_cnt_n = '0;
                    state_n   = GAP;
                    if (!m_ack_err) begin
                        done_n       = 3'b001 << idx;
                        retry_flag_n = 1'b0;
                        if (idx != REQ_INIT) begin
                            rr_last_n = idx;
                        end
                    end else if (retry_cnt < RETRY_LIM) begin
                        retry_cnt_n  = retry_cnt + 1'b1;
                        retry_flag_n = 1'b1;
                    end else begin
                        err_n        = 3'b001 << idx;
                        retry_flag_n = 1'b0;
                    end
                end else if (timer == TIMER_LAST) begin
                    err_n        = 3'b001 << idx;
                    retry_flag_n = 1'b0;
                    gap_cnt_n    = '0;
                    state_n      = GAP;
                end
            end
            GAP: begin
                // Gives the served requester time to drop req before
                // IDLE looks at the request vector again.
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt_n    = '0;
                    retry_flag_n = 1'b0;
                    state_n      = retry_flag ? ISSUE : IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer silently.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            idx        <= REQ_INIT;
            rr_last    <= REQ_KEY;
            retry_cnt  <= '0;
            retry_flag <= 1'b0;
            timer      <= '0;
            gap_cnt    <= '0;
            m_byte_hi  <= 8'h00;
            m_byte_lo  <= 8'h00;
            m_go       <= 1'b0;
            grant_done <= 3'b000;
            grant_err  <= 3'b000;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            rr_last    <= rr_last_n;
            retry_cnt  <= retry_cnt_n;
            retry_flag <= retry_flag_n;
            timer      <= timer_n;
            gap_cnt    <= gap_cnt_n;
            m_byte_hi  <= byte_hi_n;
            m_byte_lo  <= byte_lo_n;
            m_go       <= go_n;
            grant_done <= done_n;
            grant_err  <= err_n;
        end
    end

endmodule

// File: tb/tb_wm8960_i2c_arbiter.sv
// Self-checking bench for wm8960_i2c_arbiter: reset values, a table of
// directed transactions, round-robin order, retry/timeout/reset corner
// cases and randomized transactions checked against a transaction-level
// reference model.
module tb_wm8960_i2c_arbiter;

    localparam int TB_TIMEOUT = 40;
    localparam int TB_RETRY   = 2;
    localparam int TB_GAP     = 6;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       init_done;
    logic [2:0] req;
    logic [6:0] req_addr0, req_addr1, req_addr2;
    logic [8:0] req_data0, req_data1, req_data2;
    logic [2:0] grant_done, grant_err;
    logic       busy, m_go;
    logic [7:0] m_dev_addr, m_byte_hi, m_byte_lo;
    logic       m_done, m_ack_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rr_model = 2;

    typedef struct {
        logic       init_done;
        logic [2:0] req;
        logic [6:0] a0, a1, a2;
        logic [8:0] d0, d1, d2;
        int         nacks;
        logic [7:0] exp_hi, exp_lo;
        logic [2:0] exp_done, exp_err;
    } vec_t;

    vec_t vecs[8];

    wm8960_i2c_arbiter #(
        .TIMEOUT_CYC (TB_TIMEOUT),
        .RETRY_MAX   (TB_RETRY),
        .GAP_CYC     (TB_GAP)
    ) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .init_done  (init_done),
        .req        (req),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_addr2  (req_addr2),
        .req_data0  (req_data0),
        .req_data1  (req_data1),
        .req_data2  (req_data2),
        .grant_done (grant_done),
        .grant_err  (grant_err),
        .busy       (busy),
        .m_go       (m_go),
        .m_dev_addr (m_dev_addr),
        .m_byte_hi  (m_byte_hi),
        .m_byte_lo  (m_byte_lo),
        .m_done     (m_done),
        .m_ack_err  (m_ack_err)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t make_vec(input logic id, input logic [2:0] rq,
                                      input logic [6:0] a0, input logic [8:0] d0,
                                      input logic [6:0] a1, input logic [8:0] d1,
                                      input logic [6:0] a2, input logic [8:0] d2,
                                      input int nacks, input logic [7:0] hi, input logic [7:0] lo,
                                      input logic [2:0] dn, input logic [2:0] er);
        vec_t v;
        v.init_done = id; v.req = rq;
        v.a0 = a0; v.a1 = a1; v.a2 = a2;
        v.d0 = d0; v.d1 = d1; v.d2 = d2;
        v.nacks = nacks; v.exp_hi = hi; v.exp_lo = lo;
        v.exp_done = dn; v.exp_err = er;
        return v;
    endfunction

    // Reference arbitration rule: init absolute, 1 vs 2 alternate.
    function automatic int ref_winner(input logic id, input logic [2:0] rq, input int rr);
        logic e0, e1, e2;
        e0 = rq[0];
        e1 = rq[1] && id;
        e2 = rq[2] && id;
        if (e0) return 0;
        if (e1 && e2) return (rr == 1) ? 2 : 1;
        if (e1) return 1;
        if (e2) return 2;
        return -1;
    endfunction

    task automatic wait_go(input int budget, output bit seen, output int waited);
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < budget) begin
            @(negedge Clk);
            waited++;
            if (m_go) seen = 1'b1;
        end
    endtask

    task automatic wait_grant(input int budget, output bit seen);
        int waited = 0;
        while (grant_done == 3'b000 && grant_err == 3'b000 && waited < budget) begin
            @(negedge Clk);
            waited++;
        end
        seen = (grant_done != 3'b000) || (grant_err != 3'b000);
    endtask

    task automatic wait_idle(input string tag);
        int extra_go = 0;
        int w = 0;
        while (busy && w < 60) begin
            if (m_go) extra_go++;
            @(negedge Clk);
            w++;
        end
        checkOutput({tag, " extra_go"}, extra_go, 0);
        checkOutput({tag, " idle"}, busy, 1'b0);
    endtask

    task automatic expect_no_service(input int cycles, input string tag);
        int saw_busy = 0;
        int saw_go = 0;
        repeat (cycles) begin
            @(negedge Clk);
            if (busy) saw_busy++;
            if (m_go) saw_go++;
        end
        checkOutput({tag, " busy_cycles"}, saw_busy, 0);
        checkOutput({tag, " go_count"}, saw_go, 0);
    endtask

    // One full transaction from request to release, with the bench acting
    // as the I2C byte engine; answers NACK on the first v.nacks attempts.
    task automatic applyStimulus(input vec_t v, input string tag);
        bit seen;
        int w;
        int go_at;
        int winner;
        init_done = v.init_done;
        req_addr0 = v.a0; req_addr1 = v.a1; req_addr2 = v.a2;
        req_data0 = v.d0; req_data1 = v.d1; req_data2 = v.d2;
        req = v.req;
        wait_go(20, seen, w);
        checkOutput({tag, " go_latency"}, w, 2);
        if (seen) begin
            go_at = cyc;
            for (int a = 0; a <= TB_RETRY; a++) begin
                if (a > 0) begin
                    wait_go(TB_GAP + 20, seen, w);
                    checkOutput({tag, " retry_go"}, seen, 1'b1);
                    if (!seen) break;
                    checkOutput({tag, " go_spacing"}, (cyc - go_at) >= TB_GAP + 2, 1'b1);
                    go_at = cyc;
                end
                checkOutput({tag, " byte_hi"}, m_byte_hi, v.exp_hi);
                checkOutput({tag, " byte_lo"}, m_byte_lo, v.exp_lo);
                repeat (2) @(negedge Clk);
                m_done = 1'b1;
                m_ack_err = (a < v.nacks);
                @(negedge Clk);
                m_done = 1'b0;
                m_ack_err = 1'b0;
                if (a >= v.nacks) break;
            end
            wait_grant(10, seen);
        end
        checkOutput({tag, " grant_done"}, grant_done, v.exp_done);
        checkOutput({tag, " grant_err"}, grant_err, v.exp_err);
        req = 3'b000;
        @(negedge Clk);
        checkOutput({tag, " pulse_width"}, {grant_done, grant_err}, 6'b0);
        wait_idle(tag);
        winner = -1;
        for (int b = 0; b < 3; b++) if (v.exp_done[b] || v.exp_err[b]) winner = b;
        if (v.exp_done != 3'b000 && winner > 0) rr_model = winner;
    endtask

    initial begin
        bit seen;
        int w;
        int cnt;
        int go_at;
        int bad;
        int order[4];
        int addr_r[3];
        int data_r[3];
        int win;
        vec_t v;

        Rst_n = 1'b0; init_done = 1'b0; req = 3'b000;
        req_addr0 = '0; req_addr1 = '0; req_addr2 = '0;
        req_data0 = '0; req_data1 = '0; req_data2 = '0;
        m_done = 1'b0; m_ack_err = 1'b0;

        // Directed table; hi = {reg, data[8]}, lo = data[7:0].
        vecs[0] = make_vec(1'b0, 3'b111, 7'h0F, 9'h000, 7'h02, 9'h179, 7'h03, 9'h0AA, 0, 8'h1E, 8'h00, 3'b001, 3'b000);
        vecs[1] = make_vec(1'b1, 3'b010, 7'h00, 9'h000, 7'h02, 9'h179, 7'h00, 9'h000, 0, 8'h05, 8'h79, 3'b010, 3'b000);
        vecs[2] = make_vec(1'b1, 3'b110, 7'h00, 9'h000, 7'h02, 9'h179, 7'h03, 9'h0AA, 0, 8'h06, 8'hAA, 3'b100, 3'b000);
        vecs[3] = make_vec(1'b1, 3'b110, 7'h00, 9'h000, 7'h7F, 9'h1FF, 7'h03, 9'h0AA, 0, 8'hFF, 8'hFF, 3'b010, 3'b000);
        vecs[4] = make_vec(1'b1, 3'b100, 7'h00, 9'h000, 7'h00, 9'h000, 7'h15, 9'h100, 2, 8'h2B, 8'h00, 3'b100, 3'b000);
        vecs[5] = make_vec(1'b1, 3'b010, 7'h00, 9'h000, 7'h0F, 9'h0FF, 7'h00, 9'h000, 3, 8'h1E, 8'hFF, 3'b000, 3'b010);
        vecs[6] = make_vec(1'b1, 3'b011, 7'h03, 9'h155, 7'h11, 9'h022, 7'h00, 9'h000, 0, 8'h07, 8'h55, 3'b001, 3'b000);
        vecs[7] = make_vec(1'b1, 3'b110, 7'h00, 9'h000, 7'h40, 9'h001, 7'h22, 9'h033, 1, 8'h80, 8'h01, 3'b010, 3'b000);

        // Reset values
        repeat (3) @(negedge Clk);
        checkOutput("rst busy", busy, 1'b0);
        checkOutput("rst m_go", m_go, 1'b0);
        checkOutput("rst grants", {grant_done, grant_err}, 6'b0);
        checkOutput("rst bytes", {m_byte_hi, m_byte_lo}, 16'h0000);
        checkOutput("dev_addr", m_dev_addr, 8'h34);
        Rst_n = 1'b1;
        @(negedge Clk);

        // Both 1 and 2 held continuously from reset: service 1,2,1,2
        order[0] = 1; order[1] = 2; order[2] = 1; order[3] = 2;
        init_done = 1'b1;
        req_addr1 = 7'h02; req_data1 = 9'h179;
        req_addr2 = 7'h03; req_data2 = 9'h0AA;
        req = 3'b110;
        go_at = 0;
        for (int k = 0; k < 4; k++) begin
            wait_go(TB_GAP + 30, seen, w);
            checkOutput("rr go_seen", seen, 1'b1);
            if (k > 0) checkOutput("rr go_spacing", (cyc - go_at) >= TB_GAP + 2, 1'b1);
            go_at = cyc;
            checkOutput("rr byte_hi", m_byte_hi, (order[k] == 1) ? 8'h05 : 8'h06);
            checkOutput("rr byte_lo", m_byte_lo, (order[k] == 1) ? 8'h79 : 8'hAA);
            repeat (2) @(negedge Clk);
            m_done = 1'b1;
            @(negedge Clk);
            m_done = 1'b0;
            wait_grant(10, seen);
            checkOutput("rr grant_done", grant_done, 3'b001 << order[k]);
        end
        req = 3'b000;
        @(negedge Clk);
        wait_idle("rr");
        rr_model = 2;

        // Before init completes, UART/key requests are not eligible
        init_done = 1'b0;
        req = 3'b110;
        expect_no_service(15, "pre_init");

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Timeout: no m_done at all, then a late m_done during GAP
        init_done = 1'b1;
        req_addr0 = 7'h0F; req_data0 = 9'h000;
        req = 3'b001;
        wait_go(20, seen, w);
        checkOutput("to go_seen", seen, 1'b1);
        cnt = 0;
        while (grant_err == 3'b000 && grant_done == 3'b000 && cnt < TB_TIMEOUT + 20) begin
            @(negedge Clk);
            cnt++;
        end
        checkOutput("to latency", cnt, TB_TIMEOUT);
        checkOutput("to grant_err", grant_err, 3'b001);
        checkOutput("to grant_done", grant_done, 3'b000);
        req = 3'b000;
        @(negedge Clk);
        m_done = 1'b1;
        @(negedge Clk);
        m_done = 1'b0;
        bad = 0;
        repeat (30) begin
            @(negedge Clk);
            if (grant_done != 3'b000 || grant_err != 3'b000 || m_go) bad++;
        end
        checkOutput("late_done ignored", bad, 0);
        checkOutput("late_done idle", busy, 1'b0);

        // Reset while the transfer is outstanding, then re-serve
        req_addr1 = 7'h03; req_data1 = 9'h1A5;
        req = 3'b010;
        wait_go(20, seen, w);
        checkOutput("rstw go_seen", seen, 1'b1);
        #2 Rst_n = 1'b0;
        #1;
        checkOutput("rstw m_go", m_go, 1'b0);
        checkOutput("rstw busy", busy, 1'b0);
        checkOutput("rstw bytes", {m_byte_hi, m_byte_lo}, 16'h0000);
        bad = 0;
        repeat (3) begin
            @(negedge Clk);
            if (grant_done != 3'b000 || grant_err != 3'b000) bad++;
        end
        checkOutput("rstw no_pulse", bad, 0);
        Rst_n = 1'b1;
        rr_model = 2;
        applyStimulus(make_vec(1'b1, 3'b010, 7'h00, 9'h000, 7'h03, 9'h1A5, 7'h00, 9'h000,
                               0, 8'h07, 8'hA5, 3'b010, 3'b000), "rstw reserve");

        // Randomized transactions against the reference model
        for (int i = 0; i < 14; i++) begin
            v.init_done = ($urandom_range(0, 3) != 0);
            v.req = 3'($urandom_range(1, 7));
            for (int r = 0; r < 3; r++) begin
                addr_r[r] = int'($urandom_range(0, 127));
                data_r[r] = int'($urandom_range(0, 511));
            end
            v.a0 = 7'(addr_r[0]); v.a1 = 7'(addr_r[1]); v.a2 = 7'(addr_r[2]);
            v.d0 = 9'(data_r[0]); v.d1 = 9'(data_r[1]); v.d2 = 9'(data_r[2]);
            v.nacks = int'($urandom_range(0, 3));
            win = ref_winner(v.init_done, v.req, rr_model);
            if (win < 0) begin
                init_done = v.init_done;
                req = v.req;
                expect_no_service(15, $sformatf("rand%0d", i));
                req = 3'b000;
                @(negedge Clk);
            end else begin
                v.exp_hi = 8'((addr_r[win] * 2 + data_r[win] / 256) % 256);
                v.exp_lo = 8'(data_r[win] % 256);
                v.exp_done = (v.nacks <= TB_RETRY) ? 3'(1 << win) : 3'b000;
                v.exp_err  = (v.nacks <= TB_RETRY) ? 3'b000 : 3'(1 << win);
                applyStimulus(v, $sformatf("rand%0d", i));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
